riscv_mem_arbiter: RTL

- Shares one single-port unified memory between the RISC-V core's instruction-fetch port and its load/store port.
- Sits between the core and the memory model.
- Grants at most one access per cycle and tracks the owner of each in-flight read through a tag pipeline matching the memory read latency.
- Returns read data to the correct requester.
- Data port has priority; a starvation counter guarantees fetch progress.

---
 rtl/riscv_mem_pkg.sv | 16 +
 rtl/riscv_tag_pipe.sv | 36 +++
 rtl/riscv_mem_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared widths, owner encoding and the in-flight read tag used by the memory arbiter.
// Pure declarations: no latency, no flow control.
package riscv_mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    typedef struct packed {
        logic vld;
        logic own;
    } tag_t;

endpackage

// File: rtl/riscv_tag_pipe.sv
// RD_LAT-deep {valid, owner} shift register tracking which port owns each in-flight read.
// Latency RD_LAT cycles; never stalls, a synchronous clear drops every in-flight tag.
module riscv_tag_pipe
    import riscv_mem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clock,
    input  logic rst,
    input  tag_t in_tag,
    output tag_t out_tag
);

    tag_t tag_q [RD_LAT];
    tag_t tag_d [RD_LAT];

    always_comb begin
        tag_d[0] = in_tag;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < RD_LAT; i++) begin
            if (rst) begin
                tag_q[i] <= '0;
            end else begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign out_tag = tag_q[RD_LAT-1];

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one single-port memory; grants are combinational.
// Read data returns RD_LAT cycles after grant; data port wins unless fetch has been starved STARVE_LIMIT cycles.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       fetch_wins;
    tag_t       issue_tag, rsp_tag;

    assign fetch_wins = (starve_cnt_q == LIMIT);

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (!rst) begin
            if (d_req && !(if_req && fetch_wins)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wstrb = d_we ? d_wstrb : '0;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    assign mem_en = if_gnt | d_gnt;
    assign mem_we = d_gnt & d_we;

    // Counter only runs while fetch is actively being refused.
    always_comb begin
        starve_cnt_d = '0;
        if (if_req && !if_gnt) begin
            starve_cnt_d = fetch_wins ? starve_cnt_q : 4'(starve_cnt_q + 4'd1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign issue_tag.vld = mem_en & ~mem_we;
    assign issue_tag.own = d_gnt ? OWN_D : OWN_IF;

    riscv_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clock   (clock),
        .rst     (rst),
        .in_tag  (issue_tag),
        .out_tag (rsp_tag)
    );

    assign if_rvalid = !rst && rsp_tag.vld && (rsp_tag.own == OWN_IF);
    assign d_rvalid  = !rst && rsp_tag.vld && (rsp_tag.own == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

endmodule
